// File: rtl/ram_line_reader_if.sv
// Bundle of the line reader's command, RAM read port and output stream signals.
// Ports: start/base_addr/line_len command in, busy/done status out, raddr/re/rdata RAM port,
//        m_tdata/m_tvalid/m_tready/m_tlast stream. master = the reader, slave = its surroundings.
interface ram_line_reader_if #(
   parameter int DATA_WIDTH = 14,
   parameter int DATA_DEPTH = 256,
   parameter int AW         = $clog2(DATA_DEPTH),
   parameter int LW         = $clog2(DATA_DEPTH + 1)
);
   logic                  start;
   logic [AW-1:0]         base_addr;
   logic [LW-1:0]         line_len;
   logic                  busy;
   logic                  done;
   logic [AW-1:0]         raddr;
   logic                  re;
   logic [DATA_WIDTH-1:0] rdata;
   logic [DATA_WIDTH-1:0] m_tdata;
   logic                  m_tvalid;
   logic                  m_tready;
   logic                  m_tlast;

   modport master (
      input  start, base_addr, line_len, rdata, m_tready,
      output busy, done, raddr, re, m_tdata, m_tvalid, m_tlast
   );

   modport slave (
      output start, base_addr, line_len, rdata, m_tready,
      input  busy, done, raddr, re, m_tdata, m_tvalid, m_tlast
   );
endinterface

// File: rtl/ram_line_reader.sv
// Reads a line of LEN words from the line RAM starting at BASE (wrapping at DATA_DEPTH) and streams it out.
// Ports: clk, rst (async, active high), bus (ram_line_reader_if.master): command, RAM read port, stream.
// First word valid 2 cycles after accept, then 1 word/clk; m_tready low stalls via a 2-entry output FIFO.
module ram_line_reader #(
   parameter int DATA_WIDTH = 14,
   parameter int DATA_DEPTH = 256
) (
   input logic               clk,
   input logic               rst,
   ram_line_reader_if.master bus
);
   localparam int AW = $clog2(DATA_DEPTH);
   localparam int LW = $clog2(DATA_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t                state, state_nxt;
   logic [AW-1:0]         addr;
   logic [LW-1:0]         rd_left;
   logic                  inflight;
   logic                  inflight_last;
   logic [DATA_WIDTH-1:0] fifo_dat [2];
   logic                  fifo_last [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            count;
   logic [LW-1:0]         len_eff;
   logic                  accept;
   logic                  push;
   logic                  pop;
   logic                  head_last;
   logic                  re;
   logic                  busy;
   logic                  done;

   assign len_eff   = (bus.line_len > LW'(DATA_DEPTH)) ? LW'(DATA_DEPTH) : bus.line_len;
   assign accept    = (state == IDLE) && bus.start;
   assign push      = inflight;
   assign pop       = (count != 2'd0) && bus.m_tready;
   assign head_last = fifo_last[rd_ptr];

   // Next state and FSM outputs. A read is issued only if the word it returns
   // has a guaranteed FIFO slot; a pop in the same cycle frees one, which is
   // what keeps a steady 1 word/clk with only two entries.
   always_comb begin
      state_nxt = state;
      re        = 1'b0;
      busy      = (state != IDLE);
      done      = (state == DONE);
      case (state)
         IDLE: begin
            if (bus.start)
               state_nxt = (len_eff == '0) ? DONE : READ;
         end
         READ: begin
            re = (({1'b0, count} + {2'b00, inflight} - {2'b00, pop}) < 3'd2);
            if (re && (rd_left == LW'(1)))
               state_nxt = DRAIN;
         end
         DRAIN: begin
            if (pop && head_last)
               state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr          <= '0;
         rd_left       <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         wr_ptr        <= 1'b0;
         rd_ptr        <= 1'b0;
         count         <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifo_dat[i]  <= '0;
            fifo_last[i] <= 1'b0;
         end
      end else begin
         if (accept) begin
            addr    <= bus.base_addr;
            rd_left <= len_eff;
         end else if (re) begin
            // Explicit wrap so non-power-of-two depths work.
            addr    <= (addr == AW'(DATA_DEPTH - 1)) ? '0 : addr + 1'b1;
            rd_left <= rd_left - 1'b1;
         end
         // The RAM returns data one cycle after re; the last flag rides along.
         inflight      <= re;
         inflight_last <= re && (rd_left == LW'(1));
         if (push) begin
            fifo_dat[wr_ptr]  <= bus.rdata;
            fifo_last[wr_ptr] <= inflight_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign bus.raddr    = addr;
   assign bus.re       = re;
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.m_tvalid = (count != 2'd0);
   assign bus.m_tdata  = fifo_dat[rd_ptr];
   assign bus.m_tlast  = (count != 2'd0) && fifo_last[rd_ptr];
endmodule

// File: tb/tb_ram_line_reader.sv
// Bench for ram_line_reader: a 256-deep and a 10-deep instance, line model with queues, per-cycle compare.
// Ports: none (top level).
module tb_ram_line_reader;
   localparam int DW = 14;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          start = 1'b0;
   logic          sel_b = 1'b0;
   logic          tready = 1'b1;
   logic [7:0]    base = '0;
   logic [8:0]    len = '0;
   logic [DW-1:0] rdata_a = '0;
   logic [DW-1:0] rdata_b = '0;

   ram_line_reader_if #(.DATA_WIDTH(DW), .DATA_DEPTH(256)) ifa ();
   ram_line_reader_if #(.DATA_WIDTH(DW), .DATA_DEPTH(10))  ifb ();

   ram_line_reader #(.DATA_WIDTH(DW), .DATA_DEPTH(256)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   ram_line_reader #(.DATA_WIDTH(DW), .DATA_DEPTH(10))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

   assign ifa.start     = start & ~sel_b;
   assign ifa.base_addr = base;
   assign ifa.line_len  = len;
   assign ifa.m_tready  = tready;
   assign ifa.rdata     = rdata_a;
   assign ifb.start     = start & sel_b;
   assign ifb.base_addr = base[3:0];
   assign ifb.line_len  = len[3:0];
   assign ifb.m_tready  = tready;
   assign ifb.rdata     = rdata_b;

   // RAM contents: distinct word per address.
   function automatic int mem_word(input int a);
      return (a * 97 + 13) % 16384;
   endfunction

   always @(posedge clk) begin
      if (ifa.re) rdata_a <= DW'(mem_word(int'(ifa.raddr)));
      if (ifb.re) rdata_b <= DW'(mem_word(int'(ifb.raddr)));
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- line model ----------------
   bit chk_en = 1'b0;
   bit e_busy = 1'b0;
   bit e_done = 1'b0;
   int q_dat[$];
   bit q_last[$];
   int q_addr[$];
   int outstanding = 0;
   bit prev_stall = 1'b0;
   int prev_dat = 0;
   int beat_cyc[$];
   int beat_dat[$];
   int re_cyc[$];
   int re_addr[$];
   int acc_cyc = 0;
   int done_cyc = -1;

   logic c_vld, c_last, c_re, c_busy, c_done;
   int   c_dat, c_addr;
   bit   hs, exp_last;
   int   m_d, m_b, m_l, m_n;

   always @(negedge clk) begin
      if (chk_en) begin
         c_vld  = sel_b ? ifb.m_tvalid : ifa.m_tvalid;
         c_last = sel_b ? ifb.m_tlast  : ifa.m_tlast;
         c_re   = sel_b ? ifb.re       : ifa.re;
         c_busy = sel_b ? ifb.busy     : ifa.busy;
         c_done = sel_b ? ifb.done     : ifa.done;
         c_dat  = sel_b ? int'(ifb.m_tdata) : int'(ifa.m_tdata);
         c_addr = sel_b ? int'(ifb.raddr)   : int'(ifa.raddr);

         check("busy", c_busy, e_busy);
         check("done", c_done, e_done);
         if (prev_stall) begin
            check("hold_valid", c_vld, 1);
            check("hold_data", c_dat, prev_dat);
         end
         if (!c_vld) check("last_without_valid", c_last, 0);

         hs = c_vld && tready;
         exp_last = 1'b0;
         if (hs) begin
            if (q_dat.size() == 0) check("unexpected_beat", 1, 0);
            else begin
               exp_last = q_last.pop_front();
               check("beat_data", c_dat, q_dat.pop_front());
               check("beat_last", c_last, exp_last);
            end
            beat_cyc.push_back(cyc);
            beat_dat.push_back(c_dat);
         end
         if (c_re) begin
            if (q_addr.size() == 0) check("unexpected_re", 1, 0);
            else check("raddr", c_addr, q_addr.pop_front());
            check("fifo_room", ((outstanding - (hs ? 1 : 0)) < 2) ? 1 : 0, 1);
            re_cyc.push_back(cyc);
            re_addr.push_back(c_addr);
         end
         outstanding = outstanding + (c_re ? 1 : 0) - (hs ? 1 : 0);
         prev_stall  = c_vld && !tready;
         prev_dat    = c_dat;
         if (c_done) done_cyc = cyc;

         // advance expectation to the next cycle
         if (e_done) begin
            e_done = 1'b0;
            e_busy = 1'b0;
         end else if (hs && exp_last) begin
            e_done = 1'b1;
         end else if (!e_busy && start) begin
            m_d = sel_b ? 10 : 256;
            m_b = sel_b ? int'(base[3:0]) : int'(base);
            m_l = sel_b ? int'(len[3:0])  : int'(len);
            m_n = (m_l > m_d) ? m_d : m_l;
            acc_cyc = cyc + 1;
            e_busy = 1'b1;
            if (m_n == 0) e_done = 1'b1;
            for (int j = 0; j < m_n; j++) begin
               q_addr.push_back((m_b + j) % m_d);
               q_dat.push_back(mem_word((m_b + j) % m_d));
               q_last.push_back(j == m_n - 1);
            end
         end
      end
   end

   // ---------------- tready driver ----------------
   int tr_mode = 0;
   int tr_ix = 0;
   bit tr_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   initial begin
      forever begin
         @(posedge clk); #1;
         if (tr_mode == 1) begin
            tready = tr_pat[tr_ix % 6];
            tr_ix++;
         end else begin
            tready = 1'b1;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic clear_model();
      q_dat.delete(); q_last.delete(); q_addr.delete();
      outstanding = 0; e_busy = 1'b0; e_done = 1'b0; prev_stall = 1'b0;
   endtask

   task automatic clear_logs();
      beat_cyc.delete(); beat_dat.delete(); re_cyc.delete(); re_addr.delete();
      done_cyc = -1;
   endtask

   task automatic start_line(input int b, input int l);
      @(posedge clk); #1;
      base = 8'(b); len = 9'(l); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while ((e_busy || q_dat.size() != 0) && n < budget);
      check("line_finished_in_budget", e_busy, 0);
      check("all_beats_delivered", q_dat.size(), 0);
      check("all_reads_issued", q_addr.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      // reset state
      #2;
      check("rst_busy", ifa.busy, 0);
      check("rst_done", ifa.done, 0);
      check("rst_re", ifa.re, 0);
      check("rst_tvalid", ifa.m_tvalid, 0);
      check("rst_tlast", ifa.m_tlast, 0);
      check("rst_raddr", ifa.raddr, 0);
      check("rst_tdata", ifa.m_tdata, 0);
      check("rst_b_busy", ifb.busy, 0);
      repeat (3) @(posedge clk);
      #1; rst = 1'b0;
      clear_model(); chk_en = 1'b1;
      repeat (2) @(posedge clk);

      // 1: base 0, len 4, tready high
      clear_logs();
      start_line(0, 4);
      wait_idle(40);
      check("t1_beats", beat_cyc.size(), 4);
      if (beat_cyc.size() == 4 && re_cyc.size() == 4) begin
         check("t1_first_re_latency", re_cyc[0] - acc_cyc, 0);
         check("t1_re_consecutive", re_cyc[3] - re_cyc[0], 3);
         check("t1_raddr0", re_addr[0], 0);
         check("t1_raddr3", re_addr[3], 3);
         check("t1_first_beat_latency", beat_cyc[0] - acc_cyc, 2);
         check("t1_no_bubbles", beat_cyc[3] - beat_cyc[0], 3);
         check("t1_data0", beat_dat[0], 13);
         check("t1_data3", beat_dat[3], 304);
         check("t1_done_after_last", done_cyc - beat_cyc[3], 1);
      end
      repeat (2) @(posedge clk);

      // 2: depth 10, base 8, len 5 wraps
      #1; sel_b = 1'b1;
      clear_logs();
      start_line(8, 5);
      wait_idle(40);
      check("t2_beats", beat_cyc.size(), 5);
      if (re_addr.size() == 5 && beat_dat.size() == 5) begin
         check("t2_raddr0", re_addr[0], 8);
         check("t2_raddr1", re_addr[1], 9);
         check("t2_raddr2", re_addr[2], 0);
         check("t2_raddr4", re_addr[4], 2);
         check("t2_data1", beat_dat[1], 886);
         check("t2_data4", beat_dat[4], 207);
      end
      @(posedge clk); #1; sel_b = 1'b0;
      repeat (2) @(posedge clk);

      // 3: backpressure pattern 1,0,0,1,0,1
      clear_logs();
      #1; tr_ix = 0; tr_mode = 1;
      start_line(30, 6);
      wait_idle(80);
      check("t3_beats", beat_cyc.size(), 6);
      check("t3_reads", re_cyc.size(), 6);
      #1; tr_mode = 0;
      repeat (2) @(posedge clk);

      // 4a: zero length
      clear_logs();
      start_line(5, 0);
      wait_idle(10);
      check("t4_zero_beats", beat_cyc.size(), 0);
      check("t4_zero_reads", re_cyc.size(), 0);
      check("t4_zero_done_cycle", done_cyc - acc_cyc, 0);
      repeat (2) @(posedge clk);

      // 4b: oversized length clamps to depth
      clear_logs();
      start_line(100, 300);
      wait_idle(400);
      check("t4_clamp_beats", beat_cyc.size(), 256);
      check("t4_clamp_reads", re_cyc.size(), 256);
      if (re_addr.size() == 256) begin
         check("t4_wrap_before", re_addr[155], 255);
         check("t4_wrap_after", re_addr[156], 0);
      end
      repeat (2) @(posedge clk);

      // 5: start while busy is ignored
      clear_logs();
      start_line(20, 6);
      @(posedge clk); #1;
      base = 8'd50; len = 9'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle(40);
      check("t5_beats", beat_cyc.size(), 6);
      if (re_addr.size() == 6) begin
         check("t5_raddr0", re_addr[0], 20);
         check("t5_raddr5", re_addr[5], 25);
      end
      repeat (2) @(posedge clk);

      // 6: reset mid-line
      clear_logs();
      start_line(0, 8);
      for (int n = 0; n < 40 && beat_cyc.size() < 2; n++) begin
         @(posedge clk); #1;
      end
      check("t6_two_beats_seen", beat_cyc.size(), 2);
      rst = 1'b1;
      chk_en = 1'b0;
      #1;
      check("t6_async_tvalid", ifa.m_tvalid, 0);
      check("t6_async_re", ifa.re, 0);
      check("t6_async_busy", ifa.busy, 0);
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      clear_model(); clear_logs(); chk_en = 1'b1;
      repeat (3) @(posedge clk);
      check("t6_no_done_after_abort", done_cyc, -1);
      start_line(0, 2);
      wait_idle(20);
      check("t6_restart_beats", beat_cyc.size(), 2);
      if (beat_dat.size() == 2) check("t6_restart_data1", beat_dat[1], 110);
      repeat (2) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
